// File: rtl/cache_arbiter.sv
// Two-port round-robin arbiter in front of a single cache controller, with a
// sticky watchdog that flags a stalled controller.
module cache_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_rw,
  input  logic [AW-1:0] p0_addr,
  input  logic [AW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [AW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_rw,
  input  logic [AW-1:0] p1_addr,
  input  logic [AW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [AW-1:0] p1_rdata,
  output logic [AW-1:0] cache_address,
  output logic [AW-1:0] cache_data_in,
  output logic          cache_rw,
  input  logic          cache_ready,
  input  logic [AW-1:0] cache_data_out,
  output logic          busy,
  output logic          err_timeout
);

  localparam logic [6:0] L_TIMEOUT = 7'(TIMEOUT);
  localparam logic [6:0] L_WD_MAX  = 7'h7F;

  logic          r_busy;
  logic          r_owner;
  logic          r_last_grant;
  logic [AW-1:0] r_cache_address;
  logic [AW-1:0] r_cache_data_in;
  logic          r_cache_rw;
  logic [6:0]    r_wd;
  logic          r_err;

  logic          w_ack0;
  logic          w_ack1;
  logic          w_elig0;
  logic          w_elig1;
  logic          w_any;
  logic          w_grant;
  logic [6:0]    w_wd_next;

  assign w_ack0 = cache_ready & r_busy & ~r_owner;
  assign w_ack1 = cache_ready & r_busy & r_owner;

  // The port finishing on this edge is still holding req; it must not win again.
  assign w_elig0 = p0_req & ~w_ack0;
  assign w_elig1 = p1_req & ~w_ack1;
  assign w_any   = w_elig0 | w_elig1;
  assign w_grant = (w_elig0 & w_elig1) ? ~r_last_grant : w_elig1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy          <= 1'b0;
      r_owner         <= 1'b0;
      r_last_grant    <= 1'b1;
      r_cache_address <= '0;
      r_cache_data_in <= '0;
      r_cache_rw      <= 1'b0;
    end else if (cache_ready) begin
      if (w_any) begin
        r_cache_address <= w_grant ? p1_addr  : p0_addr;
        r_cache_data_in <= w_grant ? p1_wdata : p0_wdata;
        r_cache_rw      <= w_grant ? p1_rw    : p0_rw;
        r_busy          <= 1'b1;
        r_owner         <= w_grant;
        r_last_grant    <= w_grant;
      end else begin
        // Nobody waiting: keep the controller cycling on a harmless read.
        r_cache_rw <= 1'b0;
        r_busy     <= 1'b0;
      end
    end
  end

  assign w_wd_next = cache_ready        ? 7'd0 :
                     (r_wd == L_WD_MAX) ? r_wd : r_wd + 7'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wd  <= 7'd0;
      r_err <= 1'b0;
    end else begin
      r_wd <= w_wd_next;
      if (w_wd_next == L_TIMEOUT) r_err <= 1'b1;
    end
  end

  assign p0_ack        = w_ack0;
  assign p1_ack        = w_ack1;
  assign p0_rdata      = w_ack0 ? cache_data_out : '0;
  assign p1_rdata      = w_ack1 ? cache_data_out : '0;
  assign cache_address = r_cache_address;
  assign cache_data_in = r_cache_data_in;
  assign cache_rw      = r_cache_rw;
  assign busy          = r_busy;
  assign err_timeout   = r_err;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: behavioural cache environment plus a transaction-level
// arbitration/memory model; directed scenarios followed by a randomized phase.
module tb_cache_arbiter;
  localparam int TIMEOUT = 64;
  localparam int AW      = 32;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [AW-1:0] wdata;
  } txn_t;

  logic          clk;
  logic          rst_n;
  logic          p0_req, p0_rw, p1_req, p1_rw;
  logic [AW-1:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic          p0_ack, p1_ack;
  logic [AW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] cache_address, cache_data_in, cache_data_out;
  logic          cache_rw, cache_ready, busy, err_timeout;

  cache_arbiter #(.TIMEOUT(TIMEOUT), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .cache_address(cache_address), .cache_data_in(cache_data_in), .cache_rw(cache_rw),
    .cache_ready(cache_ready), .cache_data_out(cache_data_out),
    .busy(busy), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cache controller environment: random latency, miss-fill returns the address.
  logic          hold;
  int            fixed_lat;
  int            env_cnt;
  logic [AW-1:0] cmem [logic [AW-1:0]];

  function automatic int lat();
    return (fixed_lat > 0) ? fixed_lat : int'($urandom_range(4, 1));
  endfunction

  initial begin : cache_env
    cache_ready    = 1'b0;
    cache_data_out = '0;
    env_cnt        = 2;
    forever begin
      @(posedge clk); #2;
      if (!rst_n || cache_ready) begin
        cache_ready = 1'b0;
        env_cnt     = lat();
      end else if (!hold) begin
        if (env_cnt > 1) env_cnt--;
        else begin
          if (cache_rw) begin
            cmem[cache_address] = cache_data_in;
            cache_data_out      = $urandom;
          end else begin
            cache_data_out = cmem.exists(cache_address) ? cmem[cache_address] : cache_address;
          end
          cache_ready = 1'b1;
        end
      end
    end
  end

  // Requester state and reference model.
  int            vectors, miscompares;
  logic          preq [2];
  logic          prw [2];
  logic [AW-1:0] paddr [2];
  logic [AW-1:0] pwdata [2];
  logic          acked [2];
  int            wait_ops [2];
  int            n_ack [2];
  logic [AW-1:0] last_rd [2];
  int            ack_log [$];
  txn_t          q0 [$];
  txn_t          q1 [$];
  logic [AW-1:0] shadow [logic [AW-1:0]];
  logic          m_busy, m_rw, m_err, saw_ready;
  int            m_owner, m_last, m_wdc;
  logic [AW-1:0] m_addr, m_wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] exp_read(input logic [AW-1:0] a);
    return shadow.exists(a) ? shadow[a] : a;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.rw    = 1'($urandom_range(1, 0));
    t.addr  = 32'h100 + 32'(4 * $urandom_range(7, 0));
    t.wdata = $urandom;
    return t;
  endfunction

  task automatic apply();
    p0_req = preq[0]; p0_rw = prw[0]; p0_addr = paddr[0]; p0_wdata = pwdata[0];
    p1_req = preq[1]; p1_rw = prw[1]; p1_addr = paddr[1]; p1_wdata = pwdata[1];
  endtask

  task automatic present(input int i, input txn_t t);
    preq[i] = 1'b1; prw[i] = t.rw; paddr[i] = t.addr; pwdata[i] = t.wdata;
    wait_ops[i] = 0;
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      if (acked[i]) begin
        acked[i] = 1'b0;
        preq[i]  = 1'b0;
      end
      if (!preq[i]) begin
        if (i == 0 && q0.size() > 0) present(0, q0.pop_front());
        else if (i == 1 && q1.size() > 0) present(1, q1.pop_front());
      end
    end
    apply();
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_owner = 0; m_last = 1; m_addr = '0; m_rw = 1'b0; m_wd = '0;
    m_wdc = 0; m_err = 1'b0;
    for (int i = 0; i < 2; i++) begin
      preq[i] = 1'b0; prw[i] = 1'b0; paddr[i] = '0; pwdata[i] = '0;
      acked[i] = 1'b0; wait_ops[i] = 0;
    end
    q0.delete();
    q1.delete();
    apply();
  endtask

  task automatic monitor();
    int   ackp;
    int   w;
    logic e0, e1;
    ackp = (cache_ready && m_busy) ? m_owner : -1;
    chk("busy", busy, m_busy);
    chk("err_timeout", err_timeout, m_err);
    chk("p0_ack", p0_ack, ackp == 0);
    chk("p1_ack", p1_ack, ackp == 1);
    if (ackp != 0) chk("p0_rdata_idle", p0_rdata, 0);
    if (ackp != 1) chk("p1_rdata_idle", p1_rdata, 0);
    if (p0_ack) begin n_ack[0]++; ack_log.push_back(0); last_rd[0] = p0_rdata; end
    if (p1_ack) begin n_ack[1]++; ack_log.push_back(1); last_rd[1] = p1_rdata; end
    if (cache_ready) begin
      saw_ready = 1'b1;
      chk("cache_address", cache_address, m_addr);
      chk("cache_rw", cache_rw, m_rw);
      chk("cache_data_in", cache_data_in, m_wd);
      for (int i = 0; i < 2; i++) if (preq[i]) wait_ops[i]++;
      if (ackp >= 0) begin
        chk("grant_within_2_ops", wait_ops[ackp] <= 3, 1);
        if (m_rw) shadow[m_addr] = m_wd;
        else chk(ackp == 0 ? "p0_rdata" : "p1_rdata", ackp == 0 ? p0_rdata : p1_rdata,
                 exp_read(m_addr));
        acked[ackp] = 1'b1;
      end
      e0 = preq[0] && (ackp != 0);
      e1 = preq[1] && (ackp != 1);
      if (e0 || e1) begin
        w = (e0 && e1) ? 1 - m_last : (e1 ? 1 : 0);
        m_busy = 1'b1; m_owner = w; m_last = w;
        m_addr = paddr[w]; m_rw = prw[w]; m_wd = pwdata[w];
      end else begin
        m_busy = 1'b0; m_rw = 1'b0;
      end
      m_wdc = 0;
    end else if (m_wdc < 127) begin
      m_wdc++;
    end
    if (m_wdc == TIMEOUT) m_err = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk); #1;
    drive();
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || preq[0] || preq[1]) && n < budget) begin
      step();
      n++;
    end
    chk("idle_reached", n < budget, 1);
    repeat (2) step();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"}, cache_address, 0);
    chk({tag, "_din"}, cache_data_in, 0);
    chk({tag, "_rw"}, cache_rw, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err_timeout, 0);
    chk({tag, "_p0_ack"}, p0_ack, 0);
    chk({tag, "_p1_ack"}, p1_ack, 0);
  endtask

  initial begin : main
    int base, got, start0, start1, n;
    vectors = 0; miscompares = 0;
    hold = 1'b0; fixed_lat = 0; rst_n = 1'b0; saw_ready = 1'b0;
    n_ack[0] = 0; n_ack[1] = 0; last_rd[0] = '0; last_rd[1] = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Lone p0 read of an untouched line returns the miss-fill pattern.
    q0.push_back('{1'b0, 32'h0000_1004, 32'h0});
    run_until_idle(200);
    chk("r033_p0_acks", n_ack[0], 1);
    chk("r033_p1_acks", n_ack[1], 0);
    chk("r033_rdata", last_rd[0], 32'h0000_1004);

    // Write from p0 is visible to a later p1 read.
    q0.push_back('{1'b1, 32'h0000_2008, 32'hDEAD_BEEF});
    run_until_idle(200);
    q1.push_back('{1'b0, 32'h0000_2008, 32'h0});
    run_until_idle(200);
    chk("r034_p1_rdata", last_rd[1], 32'hDEAD_BEEF);

    // Simultaneous held requests alternate starting with p0.
    base = ack_log.size();
    for (int k = 0; k < 3; k++) begin
      q0.push_back('{1'b0, 32'h4000 + 32'(4 * k), 32'h0});
      q1.push_back('{1'b0, 32'h5000 + 32'(4 * k), 32'h0});
    end
    run_until_idle(400);
    for (int k = 0; k < 6; k++) begin
      got = (base + k < ack_log.size()) ? ack_log[base + k] : -1;
      chk($sformatf("r035_order%0d", k), got, k % 2);
    end

    // p0 re-requests back to back; p1 must still get through promptly.
    start1 = n_ack[1];
    for (int k = 0; k < 5; k++) q0.push_back('{1'b0, 32'h6000 + 32'(4 * k), 32'h0});
    repeat (3) step();
    q1.push_back('{1'b1, 32'h7000, 32'hCAFE_F00D});
    run_until_idle(400);
    chk("r036_p1_acks", n_ack[1] - start1, 1);

    // Randomized traffic on a small address pool.
    for (int c = 0; c < 1500; c++) begin
      if (q0.size() == 0 && $urandom_range(3, 0) == 0) q0.push_back(rand_txn());
      if (q1.size() == 0 && $urandom_range(3, 0) == 0) q1.push_back(rand_txn());
      step();
    end
    run_until_idle(200);

    // Watchdog: stall the controller right after a ready pulse.
    saw_ready = 1'b0;
    n = 0;
    while (!saw_ready && n < 50) begin step(); n++; end
    chk("r037_sync", saw_ready, 1);
    hold = 1'b1;
    repeat (63) step();
    chk("r037_err_before_64", err_timeout, 0);
    step();
    chk("r037_err_at_64", err_timeout, 1);
    repeat (6) step();
    hold = 1'b0;
    q0.push_back('{1'b0, 32'h8000, 32'h0});
    run_until_idle(200);
    chk("r037_err_sticky", err_timeout, 1);

    // Reset in the middle of a long p0 write discards it.
    fixed_lat = 6;
    start0 = n_ack[0];
    q0.push_back('{1'b1, 32'h3000, 32'h1234_5678});
    n = 0;
    while (!(m_busy && m_owner == 0) && n < 100) begin step(); n++; end
    step();
    chk("r038_busy_before_reset", busy, 1);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk_reset("r038_in_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    fixed_lat = 0;
    chk("r038_no_ack", n_ack[0] - start0, 0);
    q0.push_back('{1'b1, 32'h3000, 32'h1234_5678});
    run_until_idle(200);
    chk("r038_p0_completes", n_ack[0] - start0, 1);
    q1.push_back('{1'b0, 32'h3000, 32'h0});
    run_until_idle(200);
    chk("r038_readback", last_rd[1], 32'h1234_5678);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64: watchdog limit, in cycles, between consecutive cache_ready pulses.
REQ-002 Parameter AW, default 32: address and data width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 p0_req / p1_req  input  1  requester N has a transaction pending; it holds the signal until its ack.
REQ-006 p0_rw / p1_rw  input  1  0=read, 1=write; held stable while req=1.
REQ-007 p0_addr / p1_addr  input  AW  byte address; held stable while req=1.
REQ-008 p0_wdata / p1_wdata  input  AW  write data; held stable while req=1.
REQ-009 p0_ack / p1_ack  output  1  one-cycle completion strobe.
REQ-010 p0_rdata / p1_rdata  output  AW  read data; valid only while that port's ack=1.
REQ-011 cache_address / cache_data_in  output  AW  registered; drives the cache controller address and data_in.
REQ-012 cache_rw  output  1  registered; drives the cache controller rw.
REQ-013 cache_ready  input  1  one-cycle done pulse from the cache controller.
REQ-014 cache_data_out  input  AW  cache read data; valid while cache_ready=1.
REQ-015 busy  output  1  a requester transaction is in flight.
REQ-016 err_timeout  output  1  sticky watchdog flag.

Function
REQ-017 The cache samples its inputs every cycle it sits in IDLE; an operation always starts in the cycle after cache_ready and in the first cycle after reset.
REQ-018 The arbiter updates cache_address, cache_data_in and cache_rw only on a clock edge where cache_ready=1; they are otherwise held.
REQ-019 Each such update loads one of the following:
- a granted requester's addr, wdata and rw, with busy set and owner recorded; or
- a parked read: cache_address unchanged, cache_rw=0, cache_data_in unchanged, busy cleared.
REQ-020 Eligible requesters at an update edge are the req=1 ports, excluding the port completing at that same edge.
REQ-021 Arbitration is round-robin:
- a single eligible port wins;
- if both are eligible, the port other than last_grant wins;
- last_grant updates on every grant.
REQ-022 pX_ack = cache_ready & busy & (owner==X), combinational.
REQ-023 pX_rdata = cache_data_out when pX_ack=1, else 0; for writes, rdata content is don't-care.
REQ-024 cache_ready pulses for parked reads produce no ack and do not change last_grant.
REQ-025 A requester whose req is held continuously is granted within 2 cache operations.
REQ-026 A requester may assert a new req in the cycle after its ack; that request is eligible at the next cache_ready.
REQ-027 Watchdog: a 7-bit counter clears on each cache_ready and otherwise increments, saturating.
REQ-028 When the watchdog counter reaches TIMEOUT, err_timeout is set and stays set until reset; arbitration is unaffected.
REQ-029 A transition of req from 1 to 0 before ack is a protocol violation; behaviour is undefined, with no recovery required.

Reset
REQ-030 While rst_n=0, the block asynchronously forces:
- cache_address=0, cache_data_in=0, cache_rw=0;
- busy=0, owner=0, last_grant=1 (so p0 wins the first tie);
- watchdog counter=0, err_timeout=0.
REQ-031 The first cache operation after reset is therefore a parked read of address 0; the first requester grant occurs at the first cache_ready.
REQ-032 Reset asserted mid-transaction discards the transaction: no ack is issued, and the requester must re-present its request after reset.

Verification
REQ-033 Reset, then p0 reads 0x0000_1004 alone -> one p0_ack; p0_rdata=0x0000_1004 (miss-fill pattern); p1_ack stays 0.
REQ-034 p0 writes 0x0000_2008 with wdata 0xDEAD_BEEF, then p1 reads 0x0000_2008 -> p1_rdata=0xDEAD_BEEF.
REQ-035 p0 and p1 both assert req at the same edge and hold it, for 6 transactions -> acks alternate p0, p1, p0, p1, p0, p1.
REQ-036 p1 holds req continuously while p0 re-requests immediately after every ack -> p1 is granted within 2 cache operations of asserting req.
REQ-037 Hold cache_ready=0 for 70 cycles -> err_timeout rises at cycle 64 and stays 1 after cache_ready resumes.
REQ-038 Drop rst_n for 1 cycle mid-EVICT of a p0 write -> no p0_ack is issued; outputs return to reset values; a subsequent p0 request completes normally.
